serial_out10: RTL and testbench
===============================

Name: serial_out10

Overview:
- Parallel-in, serial-out unloader: the read side of the 10-bit parallel register path.
- Accepts a WIDTH-bit word on a valid/ready load port and emits it one bit per accepted beat on a serial valid/ready port.
- Feeds bit-serial arithmetic units (serial adders and accumulators) from parallel operand registers.

Parameters:
- WIDTH, 10, word length in bits. Must be at least 2.
- CNT_W, $clog2(WIDTH), width of the bit counter. Derived; do not override.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialise.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is valid.
- sout_last  output  1  current bit is the final bit of the word.
- sout_ready  input  1  consumer accepts sout this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state:
  - state=IDLE, shift register=0, count=0.
  - sout=0, sout_valid=0, sout_last=0.
  - load_ready=1 (follows IDLE), but any handshake while reset is asserted is ignored.
- State machine, 2 states:
  - IDLE -> SHIFT on load_valid && load_ready.
  - SHIFT -> IDLE when the last beat is accepted and no new load occurs.
  - SHIFT -> SHIFT when the last beat is accepted and a new load occurs in the same cycle.
- Load: on the load handshake, load_data is captured into the shift register and count is cleared to 0.
  - First serial bit is valid in the next cycle, giving 1-cycle latency from load to sout_valid.
- Output port:
  - sout_valid=1 exactly when state=SHIFT.
  - sout = shreg[0] (LSB first).
  - sout_last = (count==WIDTH-1) && sout_valid.
- Serial beat: a beat is sout_valid && sout_ready. On each beat the shift register shifts right by one (zero fill) and count increments.
- Backpressure: while sout_ready=0, sout, sout_last, the shift register and count hold unchanged.
- load_ready = (state==IDLE) || (sout_last && sout_ready).
  - This path is combinational from sout_ready, and it gives back-to-back words with no bubble.
  - Back-to-back: if the last beat and a new load coincide, the new word is captured, count goes to 0 and sout_valid stays 1.
- Count wrap: count never exceeds WIDTH-1. After the last beat it returns to 0 on the next load.
- Reset mid-word: the word is discarded immediately (asynchronous), outputs go to their reset values, and no partial word resumes.
- Ignored inputs: load_valid in SHIFT (other than on the last-beat cycle) has no effect. The source must hold load_data until the handshake.

Optional Feature:
- Macro: SERIAL_OUT_MSB_FIRST_EN.
- Defined: sout = shreg[WIDTH-1], the shift is left with zero fill, and the word is emitted MSB first.
- Undefined: LSB-first as above, the ordering required by carry-propagating serial adders.
- Handshake, latency and sout_last timing are identical in both builds.

Decomposition:
- Shared package serial_out_pkg holds:
  - state typedef (IDLE, SHIFT);
  - default word width constant (10);
  - counter-width function.
- Sub-module dffr: a single-bit flop with asynchronous active-high reset.
  - Used for the state bit and instantiated per bit for the shift register and counter, matching the per-bit flop style of the register blocks.

Test Plan:
- LSB-first unload: reset, then load 10'h2B5 with sout_ready=1.
  - sout over 10 consecutive cycles = 1,0,1,0,1,1,0,1,0,1.
  - sout_last is high only on the 10th bit; sout_valid drops the next cycle.
- Back-to-back: load 10'h3FF, then hold load_valid with 10'h001 so it is accepted on the last-beat cycle.
  - 20 consecutive valid beats: ten 1s, then 1 followed by nine 0s.
  - No idle cycle between words; sout_last high on beats 10 and 20.
- Backpressure: load 10'h155, then drop sout_ready for 3 cycles after bit 2.
  - sout holds at bit 2's value and count is frozen.
  - The full sequence 1,0,1,0,1,0,1,0,1,0 is still delivered with no loss or duplication.
- Reset mid-word: assert reset asynchronously, between clock edges, after 4 bits of 10'h2B5.
  - sout_valid=0 and sout=0 without waiting for a clock edge.
  - After release, load_ready=1 and a new load of 10'h0F0 serialises correctly from bit 0.
- Load ignored while busy: pulse load_valid with 10'h000 at bit 5 of 10'h3FF.
  - All 10 output bits are 1; the 10'h000 is taken only on the last-beat cycle if still held.
- With SERIAL_OUT_MSB_FIRST_EN defined: load 10'h2B5.
  - sout = 1,0,1,0,1,1,0,1,0,1 in reversed bit order, i.e. b9 first.
  - sout_last timing is unchanged.

Source files
------------

// File: rtl/serial_out_pkg.sv
// Shared types and constants for the parallel-in, serial-out unloader.
package serial_out_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 10;

    // Counter must reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/dffr.sv
// Single-bit flop with asynchronous active-high reset to zero.
module dffr (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end
endmodule

// File: rtl/serial_out10.sv
// Parallel-in, serial-out unloader with valid/ready on both sides.
// Define SERIAL_OUT_MSB_FIRST_EN to emit MSB first (default: LSB first).
module serial_out10
    import serial_out_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready
);
    state_t            state, state_nxt;
    logic              state_q, state_d;
    logic [WIDTH-1:0]  shreg, shreg_d, shifted;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              load, beat;

    dffr u_state (.clock(clock), .reset(reset), .d(state_d), .q(state_q));

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_sh
            dffr u_sh (.clock(clock), .reset(reset), .d(shreg_d[g]), .q(shreg[g]));
        end
        for (g = 0; g < CNT_W; g++) begin : g_cnt
            dffr u_cnt (.clock(clock), .reset(reset), .d(cnt_d[g]), .q(cnt[g]));
        end
    endgenerate

    assign state   = state_t'(state_q);
    assign state_d = (state_nxt == SHIFT);

`ifdef SERIAL_OUT_MSB_FIRST_EN
    assign shifted = {shreg[WIDTH-2:0], 1'b0};
    assign sout    = shreg[WIDTH-1];
`else
    assign shifted = {1'b0, shreg[WIDTH-1:1]};
    assign sout    = shreg[0];
`endif

    assign sout_valid = (state == SHIFT);
    assign sout_last  = sout_valid && (cnt == CNT_W'(WIDTH-1));
    // Combinational from sout_ready so a new word lands on the last beat.
    assign load_ready = (state == IDLE) || (sout_last && sout_ready);
    assign load       = load_valid && load_ready;
    assign beat       = sout_valid && sout_ready;

    always_comb begin
        state_nxt = state;
        shreg_d   = shreg;
        cnt_d     = cnt;
        if (load) begin
            state_nxt = SHIFT;
            shreg_d   = load_data;
            cnt_d     = '0;
        end else if (beat) begin
            shreg_d = shifted;
            // Count parks at WIDTH-1 after the final beat until the next load.
            if (sout_last) state_nxt = IDLE;
            else           cnt_d     = cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_serial_out10.sv
// Directed self-checking bench for serial_out10 (honours SERIAL_OUT_MSB_FIRST_EN).
module tb_serial_out10;
    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] load_data;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;
    logic       sout_ready;

    int total = 0;
    int bad   = 0;

    serial_out10 dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .sout_ready (sout_ready)
    );

    always #5 clock = ~clock;

    // Expected serial bit i of a word in emission order.
    function automatic logic eb(input logic [9:0] w, input int i);
`ifdef SERIAL_OUT_MSB_FIRST_EN
        return w[9-i];
`else
        return w[i];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    initial begin
        // 0x2B5 emits 1,0,1,0,1,1,0,1,0,1 in either bit order.
        logic [9:0] seq_2b5;
        seq_2b5 = 10'b1010110101;

        reset = 1'b1; load_valid = 1'b0; load_data = '0; sout_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(sout_valid), 0);
        chk("rst_sout",  32'(sout), 0);
        chk("rst_last",  32'(sout_last), 0);
        chk("rst_ready", 32'(load_ready), 1);
        load_valid = 1'b1; load_data = 10'h3FF;
        tick;
        chk("rst_hs_ignored", 32'(sout_valid), 0);
        #5;
        reset = 1'b0; load_valid = 1'b0;
        tick;
        chk("idle_valid", 32'(sout_valid), 0);

        // LSB-first (or MSB-first) unload of 0x2B5
        load_valid = 1'b1; load_data = 10'h2B5;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_valid%0d", i), 32'(sout_valid), 1);
            chk($sformatf("t1_bit%0d", i),   32'(sout), 32'(seq_2b5[i]));
            chk($sformatf("t1_last%0d", i),  32'(sout_last), 32'(i == 9));
            tick;
        end
        chk("t1_done_valid", 32'(sout_valid), 0);
        chk("t1_done_ready", 32'(load_ready), 1);

        // Back-to-back 0x3FF then 0x001
        load_valid = 1'b1; load_data = 10'h3FF;
        tick;
        load_data = 10'h001;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t2_valid%0d", i), 32'(sout_valid), 1);
            chk($sformatf("t2_bit%0d", i),   32'(sout),
                32'((i < 10) ? 1'b1 : eb(10'h001, i - 10)));
            chk($sformatf("t2_last%0d", i),  32'(sout_last), 32'(i == 9 || i == 19));
            chk($sformatf("t2_lrdy%0d", i),  32'(load_ready), 32'(i == 9 || i == 19));
            tick;
            if (i == 9) load_valid = 1'b0;
        end
        chk("t2_done_valid", 32'(sout_valid), 0);

        // Backpressure on 0x155
        load_valid = 1'b1; load_data = 10'h155;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_bit%0d", i),  32'(sout), 32'(eb(10'h155, i)));
            chk($sformatf("t3_last%0d", i), 32'(sout_last), 32'(i == 9));
            if (i == 2) begin
                sout_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick;
                    chk($sformatf("t3_hold_bit%0d", s),   32'(sout), 32'(eb(10'h155, 2)));
                    chk($sformatf("t3_hold_valid%0d", s), 32'(sout_valid), 1);
                    chk($sformatf("t3_hold_last%0d", s),  32'(sout_last), 0);
                end
                sout_ready = 1'b1;
            end
            tick;
        end
        chk("t3_done_valid", 32'(sout_valid), 0);

        // Asynchronous reset mid-word
        load_valid = 1'b1; load_data = 10'h2B5;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_bit%0d", i), 32'(sout), 32'(seq_2b5[i]));
            tick;
        end
        #1 reset = 1'b1;
        #1;
        chk("t4_async_valid", 32'(sout_valid), 0);
        chk("t4_async_sout",  32'(sout), 0);
        chk("t4_async_last",  32'(sout_last), 0);
        #2 reset = 1'b0;
        #1;
        chk("t4_post_ready", 32'(load_ready), 1);
        load_valid = 1'b1; load_data = 10'h0F0;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_new_bit%0d", i),  32'(sout), 32'(eb(10'h0F0, i)));
            chk($sformatf("t4_new_last%0d", i), 32'(sout_last), 32'(i == 9));
            tick;
        end
        chk("t4_done_valid", 32'(sout_valid), 0);

        // Load held from bit 5 of 0x3FF: ignored until the last beat
        load_valid = 1'b1; load_data = 10'h3FF;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_bit%0d", i), 32'(sout), 1);
            if (i == 5) begin
                load_valid = 1'b1; load_data = 10'h000;
            end
            tick;
        end
        load_valid = 1'b0;
        chk("t5_reload_valid", 32'(sout_valid), 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_zero%0d", i),  32'(sout), 0);
            chk($sformatf("t5_zlast%0d", i), 32'(sout_last), 32'(i == 9));
            tick;
        end
        chk("t5_done_valid", 32'(sout_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
